// File: rtl/hc02_pkg.sv
// Shared definitions for the hc02 input conditioner: channel state encoding
// and default synchronizer / debounce parameters.
package hc02_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } ch_state_e;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 1000;

endpackage

// File: rtl/hc02_debounce_ch.sv
// One conditioning channel: pad synchronizer, debounce FSM with qualify
// counter, and registered single-cycle rise/fall strobes.
module hc02_debounce_ch
  import hc02_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic qualify
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_p1;
  ch_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_d, rise_d, fall_d;

  // Stage p0: metastability chain; only the last flop is trusted downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_p0 <= '0;
    else     sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
  end

  assign sync_p1 = sync_p0[SYNC_STAGES-1];

  // Stage p1: debounce state, counter, conditioned level and strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      dout    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout    <= dout_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE: begin
        if (sync_p1 != dout) begin
          state_d = QUALIFY;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      QUALIFY: begin
        if (sync_p1 == dout) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Counter saturates here by construction, so it can never wrap
          state_d = STABLE;
          cnt_d   = '0;
          dout_d  = sync_p1;
          rise_d  = sync_p1;
          fall_d  = ~sync_p1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign qualify = (state_q == QUALIFY);

endmodule

// File: rtl/hc02_in_cond.sv
// Input conditioner for the two inputs of an hc02 NOR stage: two independent
// debounced channels plus a registered busy flag.
module hc02_in_cond
  import hc02_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic a_o,
  output logic b_o,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic busy
);

  logic qual_a, qual_b;

  hc02_debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch_a (
    .clk    (clk),
    .rst    (rst),
    .din    (a),
    .dout   (a_o),
    .rise   (a_rise),
    .fall   (a_fall),
    .qualify(qual_a)
  );

  hc02_debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch_b (
    .clk    (clk),
    .rst    (rst),
    .din    (b),
    .dout   (b_o),
    .rise   (b_rise),
    .fall   (b_fall),
    .qualify(qual_b)
  );

  // Stage p2: busy is registered from the channel state flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else     busy <= qual_a | qual_b;
  end

endmodule

// File: tb/tb_hc02_in_cond.sv
// Self-checking bench for hc02_in_cond (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
// against a window-based reference model of the sampled pad history.
module tb_hc02_in_cond;

  localparam int S = 2;
  localparam int D = 4;

  logic clk, rst, a, b;
  logic a_o, b_o, a_rise, a_fall, b_rise, b_fall, busy;

  hc02_in_cond #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .a_o(a_o), .b_o(b_o), .a_rise(a_rise), .a_fall(a_fall),
    .b_rise(b_rise), .b_fall(b_fall), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk = 0;
  int err = 0;

  // Reference model: raw pad samples since reset release; a channel's
  // output flips when the last D samples its FSM has seen all differ.
  logic ha [0:4095];
  logic hb [0:4095];
  int   n;
  logic ma_o, mb_o, mqa, mqb, mbusy, mar, maf, mbr, mbf;
  logic [6:0] obs, exp_v;

  function automatic logic seen(input logic ch, input int idx);
    if (idx < 0) return 1'b0;
    return ch ? hb[idx] : ha[idx];
  endfunction

  function automatic logic window_differs(input logic ch, input logic out);
    for (int j = 0; j < D; j++)
      if (seen(ch, n - S - j) == out) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_clear();
    n = 0;
    ma_o = 0; mb_o = 0; mqa = 0; mqb = 0; mbusy = 0;
    mar = 0; maf = 0; mbr = 0; mbf = 0;
  endfunction

  function automatic void model_edge();
    logic cha, chb, sa, sb;
    ha[n] = a;
    hb[n] = b;
    sa  = seen(1'b0, n - S);
    sb  = seen(1'b1, n - S);
    cha = window_differs(1'b0, ma_o);
    chb = window_differs(1'b1, mb_o);
    mbusy = mqa | mqb;
    mar = cha & ~ma_o;  maf = cha & ma_o;
    mbr = chb & ~mb_o;  mbf = chb & mb_o;
    mqa = (sa != ma_o) && !cha;
    mqb = (sb != mb_o) && !chb;
    if (cha) ma_o = ~ma_o;
    if (chb) mb_o = ~mb_o;
    n++;
  endfunction

  // Drive inputs away from the edge, advance one clock, sample at +1.
  task automatic tick(input logic na, input logic nb);
    a = na;
    b = nb;
    @(posedge clk);
    model_edge();
    #1;
    obs   = {a_o, b_o, a_rise, a_fall, b_rise, b_fall, busy};
    exp_v = {ma_o, mb_o, mar, maf, mbr, mbf, mbusy};
  endtask

  task automatic apply_reset(input logic ra, input logic rb);
    a = ra;
    b = rb;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    int ea, eb;
    ea = -1; eb = -1;
    a = 1'b1; b = 1'b1; rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk++;
    if ({a_o, b_o, a_rise, a_fall, b_rise, b_fall, busy} !== 7'b0) begin
      err++;
      $display("FAIL reset_state got=%b exp=%b", {a_o, b_o, a_rise, a_fall, b_rise, b_fall, busy}, 7'b0);
    end
    rst = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick(1'b1, 1'b1);
      chk++;
      if (obs !== exp_v) begin
        err++;
        $display("FAIL reset_release edge=%0d got=%b exp=%b", t, obs, exp_v);
      end
      if (a_rise && ea < 0) ea = t;
      if (b_rise && eb < 0) eb = t;
    end
    chk++;
    if (ea !== 6 || eb !== 6) begin
      err++;
      $display("FAIL reset_rise_edge got a=%0d b=%0d exp=6", ea, eb);
    end
  endtask

  task automatic test_glitch();
    logic saw_busy, saw_strobe;
    saw_busy = 0; saw_strobe = 0;
    apply_reset(1'b0, 1'b0);
    for (int t = 1; t <= 12; t++) begin
      tick((t <= 3), 1'b0);
      chk++;
      if (obs !== exp_v) begin
        err++;
        $display("FAIL glitch edge=%0d got=%b exp=%b", t, obs, exp_v);
      end
      saw_busy   |= busy;
      saw_strobe |= a_rise | a_fall;
    end
    chk++;
    if (!saw_busy || saw_strobe || a_o !== 1'b0 || busy !== 1'b0) begin
      err++;
      $display("FAIL glitch_summary got busy_seen=%b strobe=%b a_o=%b busy=%b exp=1 0 0 0", saw_busy, saw_strobe, a_o, busy);
    end
  endtask

  task automatic test_bounce();
    int rises, er;
    rises = 0; er = -1;
    for (int t = 0; t < 10; t++) begin
      tick((t % 2) == 0, 1'b0);
      chk++;
      if (obs !== exp_v) begin
        err++;
        $display("FAIL bounce_toggle step=%0d got=%b exp=%b", t, obs, exp_v);
      end
      rises += a_rise;
    end
    for (int t = 1; t <= 10; t++) begin
      tick(1'b1, 1'b0);
      chk++;
      if (obs !== exp_v) begin
        err++;
        $display("FAIL bounce_hold edge=%0d got=%b exp=%b", t, obs, exp_v);
      end
      rises += a_rise;
      if (a_rise && er < 0) er = t;
    end
    chk++;
    if (rises !== 1 || er !== 6) begin
      err++;
      $display("FAIL bounce_rise got count=%0d edge=%0d exp count=1 edge=6", rises, er);
    end
  endtask

  task automatic test_fall();
    int falls, rises, ef;
    falls = 0; rises = 0; ef = -1;
    for (int t = 1; t <= 10; t++) begin
      tick(1'b0, 1'b0);
      chk++;
      if (obs !== exp_v) begin
        err++;
        $display("FAIL fall edge=%0d got=%b exp=%b", t, obs, exp_v);
      end
      falls += a_fall;
      rises += a_rise;
      if (a_fall && ef < 0) ef = t;
    end
    chk++;
    if (falls !== 1 || rises !== 0 || ef !== 6 || a_o !== 1'b0) begin
      err++;
      $display("FAIL fall_summary got falls=%0d rises=%0d edge=%0d a_o=%b exp 1 0 6 0", falls, rises, ef, a_o);
    end
  endtask

  task automatic test_reset_mid();
    int er;
    er = -1;
    apply_reset(1'b0, 1'b0);
    for (int t = 1; t <= 3; t++) begin
      tick(1'b1, 1'b0);
      chk++;
      if (obs !== exp_v) begin
        err++;
        $display("FAIL midrst_pre edge=%0d got=%b exp=%b", t, obs, exp_v);
      end
    end
    rst = 1'b1;
    model_clear();
    #1;
    chk++;
    if ({a_o, a_rise, a_fall, busy} !== 4'b0) begin
      err++;
      $display("FAIL midrst_async got=%b exp=0000", {a_o, a_rise, a_fall, busy});
    end
    @(posedge clk);
    #1;
    chk++;
    if ({a_o, a_rise, a_fall, busy} !== 4'b0) begin
      err++;
      $display("FAIL midrst_held got=%b exp=0000", {a_o, a_rise, a_fall, busy});
    end
    rst = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      tick(1'b1, 1'b0);
      chk++;
      if (obs !== exp_v) begin
        err++;
        $display("FAIL midrst_post edge=%0d got=%b exp=%b", t, obs, exp_v);
      end
      if (a_rise && er < 0) er = t;
    end
    chk++;
    if (er !== 6) begin
      err++;
      $display("FAIL midrst_rise_edge got=%0d exp=6", er);
    end
  endtask

  task automatic test_independence();
    int ea, eb, first_busy;
    logic busy_gap;
    ea = -1; eb = -1; first_busy = -1; busy_gap = 0;
    apply_reset(1'b0, 1'b0);
    for (int t = 1; t <= 12; t++) begin
      tick(1'b1, (t >= 3));
      chk++;
      if (obs !== exp_v) begin
        err++;
        $display("FAIL indep edge=%0d got=%b exp=%b", t, obs, exp_v);
      end
      if (busy && first_busy < 0) first_busy = t;
      if (first_busy >= 0 && eb < 0 && !busy) busy_gap = 1;
      if (a_rise && ea < 0) ea = t;
      if (b_rise && eb < 0) eb = t;
    end
    chk++;
    if (ea !== 6 || eb !== 8 || busy_gap !== 1'b0 || first_busy < 0) begin
      err++;
      $display("FAIL indep_summary got a=%0d b=%0d gap=%b busy_from=%0d exp a=6 b=8 gap=0", ea, eb, busy_gap, first_busy);
    end
  endtask

  task automatic test_random();
    logic va, vb;
    int la, lb;
    va = 0; vb = 0; la = 0; lb = 0;
    apply_reset(1'b0, 1'b0);
    for (int t = 0; t < 600; t++) begin
      if (la == 0) begin va = $urandom_range(0, 1); la = $urandom_range(1, 8); end
      if (lb == 0) begin vb = $urandom_range(0, 1); lb = $urandom_range(1, 8); end
      la--; lb--;
      tick(va, vb);
      chk++;
      if (obs !== exp_v) begin
        err++;
        $display("FAIL random step=%0d got=%b exp=%b", t, obs, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1; a = 1'b0; b = 1'b0;
    model_clear();
    test_reset();
    test_glitch();
    test_bounce();
    test_fall();
    test_reset_mid();
    test_independence();
    test_random();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule

// File: doc/hc02_in_cond.md
HC02_IN_COND -- requirements
Module: hc02_in_cond

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, default 2, number of synchronizer flops per input; legal range 2..4.
REQ-002 SHALL have parameter: DEBOUNCE_CYCLES, default 1000, number of consecutive clocks a new level must persist before acceptance; legal range 2..65535.
REQ-003 SHALL have port: clk  input  1  single system clock; all flops on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port: a  input  1  raw pad input A, asynchronous to clk.
REQ-006 SHALL have port: b  input  1  raw pad input B, asynchronous to clk.
REQ-007 SHALL have port: a_o  output  1  conditioned A, drives input A of the hc02 NOR stage.
REQ-008 SHALL have port: b_o  output  1  conditioned B, drives input B of the hc02 NOR stage.
REQ-009 SHALL have port: a_rise, a_fall, b_rise, b_fall  output  1 each  single-cycle edge strobes on the conditioned outputs.
REQ-010 SHALL have port: busy  output  1  high while either channel is qualifying a pending change.

Function
REQ-011 Each channel SHALL pass its raw input through a SYNC_STAGES-deep flop chain; only the last stage (sync) feeds the debounce logic.
REQ-012 Each channel SHALL implement a two-state FSM: STABLE and QUALIFY, with a counter of width clog2(DEBOUNCE_CYCLES).
REQ-013 STABLE: if sync == output, stay, counter held at 0; if sync != output, go to QUALIFY, counter <= 1.
REQ-014 QUALIFY: if sync == output (glitch), return to STABLE, counter <= 0, output unchanged, no strobe.
REQ-015 QUALIFY: if sync != output and counter == DEBOUNCE_CYCLES-1, output <= sync, fire exactly one strobe (rise if new value 1, fall if 0) in the same cycle the output changes, go to STABLE, counter <= 0.
REQ-016 QUALIFY: otherwise counter <= counter+1; the counter SHALL never wrap.
REQ-017 Latency: a clean raw level change SHALL appear on the output exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-018 A pulse on the sync signal shorter than DEBOUNCE_CYCLES clocks SHALL produce no output change and no strobe.
REQ-019 Channels SHALL be fully independent; simultaneous changes on a and b SHALL update a_o and b_o in the same cycle and fire both strobes.
REQ-020 Edge strobes SHALL be registered, high for exactly one clock, and never asserted in consecutive cycles on the same channel.
REQ-021 busy SHALL be the registered OR of both channels being in QUALIFY.

Reset
REQ-022 rst high SHALL asynchronously clear all sync flops, counters, FSMs (to STABLE), a_o, b_o, all strobes and busy to 0.
REQ-023 rst asserted mid-QUALIFY SHALL abort qualification with no strobe; after release a held-high pad SHALL produce a rise after the full REQ-017 latency.
REQ-024 No output SHALL glitch or strobe in the cycle of reset deassertion.

Structure
REQ-025 A shared package hc02_pkg SHALL hold the channel state enum (STABLE, QUALIFY) and default values for SYNC_STAGES and DEBOUNCE_CYCLES.
REQ-026 One sub-module hc02_debounce_ch (synchronizer, FSM, counter, strobes for one channel) SHALL be instantiated twice; the top holds only instantiation and busy.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-027 Reset: rst=1 with a=b=1 -> a_o=b_o=0, strobes=0, busy=0; release, hold a=b=1 -> a_o, b_o rise on edge 6, a_rise and b_rise high that cycle only.
REQ-028 Glitch: a high for 3 clocks then low -> a_o stays 0, no strobe, busy high then back to 0.
REQ-029 Bounce: a toggles every clock for 10 clocks then holds 1 -> single a_rise exactly 6 edges after the final transition.
REQ-030 Fall: a_o=1, a driven 0 -> a_o=0 after 6 edges, one a_fall, a_rise never asserted.
REQ-031 Reset mid-qualify: a rises, rst pulsed on edge 4 -> no strobe; a still 1 -> a_rise 6 edges after reset release.
REQ-032 Independence: a rises, b rises 2 clocks later -> a_rise and b_rise separated by exactly 2 clocks; busy high continuously from first qualify to last strobe.
